// File: rtl/item_pack.sv
// item_pack: shared constants and the one-hot port vector type for the switch register file
package item_pack;
  localparam int NUM_PORTS = 4;
  localparam int DATA_W = 8;
  typedef logic [NUM_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/switch_addr_match.sv
// switch_addr_match: compares a destination address against every valid port address, keeps the lowest-index hit
module switch_addr_match
  import item_pack::*;
#(
  parameter int NUM_PORTS = item_pack::NUM_PORTS,
  parameter int DATA_W = item_pack::DATA_W
) (
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]             addr_valid,
  input  logic [DATA_W-1:0]                lookup_da,
  output logic [NUM_PORTS-1:0]             hit,
  output logic                             no_hit
);
  logic found;
  // walk upward so the first valid match wins and later ones are masked
  always_comb begin
    hit = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && addr_valid[i] && port_addr[i] == lookup_da) begin
        hit[i] = 1'b1;
        found = 1'b1;
      end
    end
    no_hit = !found;
  end
endmodule

// File: rtl/switch_mem_regfile.sv
// switch_mem_regfile: port-address register file with a one-cycle lookup path; SWITCH_MEM_CONFLICT_EN adds a duplicate-address flag
module switch_mem_regfile
  import item_pack::*;
#(
  parameter int NUM_PORTS = item_pack::NUM_PORTS,
  parameter int DATA_W = item_pack::DATA_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic [1:0]           mem_add,
  input  logic                 mem_en,
  input  logic                 mem_rd_wr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 lookup_valid,
  input  logic [DATA_W-1:0]    lookup_da,
  output logic                 match_valid,
  output logic [NUM_PORTS-1:0] match_port,
  output logic                 miss,
  output logic                 conflict
);
  logic [NUM_PORTS-1:0][DATA_W-1:0] port_addr;
  logic [NUM_PORTS-1:0]             addr_valid;
  logic [DATA_W-1:0]                rd_sel;
  logic [NUM_PORTS-1:0]             hit;
  logic                             no_hit;
  logic                             wr_en;
  logic                             rd_en;
  assign wr_en = mem_en && mem_rd_wr;
  assign rd_en = mem_en && !mem_rd_wr;
  // register writes; an out-of-range index simply matches no register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port_addr <= '0;
      addr_valid <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (int'(mem_add) == i) begin
          port_addr[i] <= mem_data;
          addr_valid[i] <= 1'b1;
        end
      end
    end
  end
  // read mux over the current register contents
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) rd_sel = (int'(mem_add) == i) ? port_addr[i] : rd_sel;
  end
  // read response: rd_valid pulses one cycle, rd_data holds between reads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_data <= rd_en ? rd_sel : rd_data;
    end
  end
  switch_addr_match #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W)) u_match (
    .port_addr (port_addr),
    .addr_valid(addr_valid),
    .lookup_da (lookup_da),
    .hit       (hit),
    .no_hit    (no_hit)
  );
  // lookup result registered from pre-write contents; qualifiers force zeros when idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_valid <= 1'b0;
      match_port <= '0;
      miss <= 1'b0;
    end else begin
      match_valid <= lookup_valid;
      match_port <= lookup_valid ? hit : '0;
      miss <= lookup_valid && no_hit;
    end
  end
`ifdef SWITCH_MEM_CONFLICT_EN
  logic dup;
  // any pair of valid registers holding the same address
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = i + 1; j < NUM_PORTS; j++)
        dup = dup || (addr_valid[i] && addr_valid[j] && port_addr[i] == port_addr[j]);
  end
  // flag lags the register state by one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) conflict <= 1'b0;
    else conflict <= dup;
  end
`else
  assign conflict = 1'b0;
`endif
endmodule

// File: doc/switch_mem_regfile.md
SWITCH_MEM_REGFILE -- requirements
Module: switch_mem_regfile

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 4, giving the number of switch output ports and port-address registers.
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the width of the memory data bus and of each port address.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port mem_data, input, DATA_W bits: write data.
REQ-006 The module SHALL have port mem_add, input, 2 bits: register index.
REQ-007 The module SHALL have port mem_en, input, 1 bit: access enable.
REQ-008 The module SHALL have port mem_rd_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 The module SHALL have port rd_data, output, DATA_W bits: read result.
REQ-010 The module SHALL have port rd_valid, output, 1 bit: rd_data qualifier.
REQ-011 The module SHALL have port lookup_valid, input, 1 bit: request to look up a destination address.
REQ-012 The module SHALL have port lookup_da, input, DATA_W bits: destination address to look up.
REQ-013 The module SHALL have port match_valid, output, 1 bit: lookup result qualifier.
REQ-014 The module SHALL have port match_port, output, NUM_PORTS bits: one-hot matching port.
REQ-015 The module SHALL have port miss, output, 1 bit: lookup found no match.
REQ-016 The module SHALL have port conflict, output, 1 bit: duplicate configured address.

Function
REQ-017 Write: at a rising edge with mem_en=1 and mem_rd_wr=1, the block SHALL update port_addr[mem_add] to mem_data and set addr_valid[mem_add] to 1 at that same edge.
REQ-018 Read: at a rising edge with mem_en=1 and mem_rd_wr=0, the block SHALL drive rd_data=port_addr[mem_add] and rd_valid=1 for exactly the next cycle; otherwise rd_valid=0 and rd_data SHALL hold its last value.
REQ-019 A read of a never-written register SHALL return 0x00.
REQ-020 With mem_en=0, mem_data, mem_add and mem_rd_wr SHALL be ignored.
REQ-021 Lookup: at a rising edge with lookup_valid=1, the block SHALL, one cycle later, pulse match_valid=1 for one cycle and set match_port to the one-hot lowest index i with addr_valid[i]=1 and port_addr[i]==lookup_da.
REQ-022 If no valid register matches, the block SHALL drive match_port=0 and miss=1 together with match_valid.
REQ-023 miss and match_port SHALL be 0 whenever match_valid=0.
REQ-024 A lookup and a write in the same cycle SHALL use the pre-write register contents; the new value SHALL be visible from the next lookup onward.
REQ-025 Back-to-back lookups on consecutive cycles SHALL each produce a result; throughput SHALL be one lookup per cycle with fixed latency 1.
REQ-026 Mem access and lookup SHALL be independent; both MAY occur in the same cycle without stall.

Reset
REQ-027 While reset_n=0, the block SHALL clear all port_addr and addr_valid to 0 and drive rd_data, rd_valid, match_valid, match_port, miss and conflict to 0, asynchronously.
REQ-028 A request in flight when reset asserts SHALL be dropped with no output pulse after reset is released.

Configuration
REQ-029 With SWITCH_MEM_CONFLICT_EN defined, conflict SHALL be a registered flag, high starting one cycle after any edge that leaves two valid registers with equal port_addr, and low one cycle after the duplicate is removed.
REQ-030 Without SWITCH_MEM_CONFLICT_EN, conflict SHALL be tied to 0 and the comparison logic SHALL not be synthesized.

Structure
REQ-031 The package item_pack SHALL hold the NUM_PORTS and DATA_W constants and the typedef for the one-hot port vector.
REQ-032 The address-match comparator array plus lowest-index priority encoder SHALL be a sub-module named switch_addr_match.

Verification
REQ-033 Reset then read all 4 registers -> rd_valid pulses, each with rd_data=0x00.
REQ-034 Write 0x11, 0x22, 0x33, 0x44 to addresses 0-3, then lookup_da=0x33 -> one cycle later match_valid=1, match_port=4'b0100, miss=0.
REQ-035 Lookup_da=0x55 with the config from REQ-034 -> match_valid=1, match_port=0, miss=1.
REQ-036 In the same cycle write address 2 with 0x55 and look up 0x55 -> miss=1; a repeat lookup on the next cycle -> match_port=4'b0100.
REQ-037 With SWITCH_MEM_CONFLICT_EN defined, write 0x22 to address 3 while address 1 holds 0x22 -> conflict=1 one cycle later; lookup 0x22 -> match_port=4'b0010; rewrite address 3 with 0x44 -> conflict=0.
REQ-038 Assert reset_n=0 mid-lookup -> no match_valid pulse appears, and all registers read back as 0x00.
